return_stack_controller: RTL
============================

RETURN_STACK_CONTROLLER -- requirements
Module: return_stack_controller

Interface
REQ-001 Parameter PC_WIDTH, default 8: width of stored return addresses.
REQ-002 Parameter STACK_DEPTH, default 16, power of two >= 2: number of stack entries.
REQ-003 The block SHALL provide the following ports:
- clock  input  1  single clock; all state updates on its rising edge.
- isResetN  input  1  reset, asynchronous, active-low.
- push  input  1  CALL request; push pushValue this cycle.
- pop  input  1  EXIT request; pop top entry this cycle.
- pushValue  input  PC_WIDTH  return address to push (pc+1 from CPU).
- flush  input  1  synchronous empty of the stack; errors are kept.
- clearErrors  input  1  synchronous clear of both sticky error flags.
- topValue  output  PC_WIDTH  registered copy of the top entry; 0 when empty.
- depth  output  log2(STACK_DEPTH)+1  registered current entry count.
- full  output  1  depth == STACK_DEPTH.
- empty  output  1  depth == 0.
- overflowError  output  1  sticky; set by a rejected push.
- underflowError  output  1  sticky; set by a rejected pop.
- highWater  output  log2(STACK_DEPTH)+1  registered maximum depth reached since reset or flush.

Function
REQ-004 The block SHALL accept at most one operation per cycle, chosen by priority: flush, then push+pop, then push, then pop.
REQ-005 Push when not full SHALL write pushValue at index depth and increment depth; topValue SHALL equal pushValue in the next cycle.
REQ-006 Pop when not empty SHALL decrement depth; topValue SHALL equal the new top entry in the next cycle, or 0 if the stack is now empty.
REQ-007 Push+pop when not empty (tail call) SHALL overwrite the top entry with pushValue and leave depth unchanged; this SHALL be legal when full and SHALL NOT set overflowError.
REQ-008 Push+pop when empty SHALL act as a plain push with no underflow.
REQ-009 Push when full (without pop) SHALL be ignored: storage, depth and topValue stay unchanged, and overflowError is set in the next cycle.
REQ-010 Pop when empty SHALL be ignored: depth stays 0, topValue stays 0, and underflowError is set in the next cycle.
REQ-011 Flush SHALL set depth, topValue and highWater to 0 in the next cycle, overriding push and pop; storage contents need not be cleared.
REQ-012 If clearErrors and a new error occur in the same cycle, the new error SHALL win and the flag is 1 next cycle.
REQ-013 highWater SHALL update in the same cycle as depth, to max(highWater, new depth).
REQ-014 Depth arithmetic SHALL never wrap: the count stays within 0..STACK_DEPTH.
REQ-015 The index for a push is depth; the index for the top entry is depth-1, computed modulo STACK_DEPTH at log2(STACK_DEPTH) bits.
REQ-016 full and empty SHALL be decoded combinationally from registered depth; no other output depends combinationally on inputs.
REQ-017 Latency SHALL be exactly one cycle from request to updated outputs, with no stalls.

Reset
REQ-018 While isResetN is 0, the following outputs SHALL be 0 asynchronously: depth, topValue, overflowError, underflowError, highWater. empty is 1 and full is 0.
REQ-019 Reset asserted mid-operation SHALL abandon the operation; storage contents are undefined after reset and are never observable.
REQ-020 Release of isResetN SHALL be synchronous to clock; the first operation is accepted on the first rising edge after release.

Structure
REQ-021 The constants PC_WIDTH and STACK_DEPTH, and the derived depth width, SHALL live in the shared CPU package used by the CPU and ALU.
REQ-022 Storage SHALL be a sub-module, stack_ram: STACK_DEPTH x PC_WIDTH, one synchronous write port and one asynchronous read port, with no reset.
REQ-023 The control logic (depth counter, error flags, highWater, topValue register) SHALL reside in return_stack_controller.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Reset, then push 8'h05, 8'h11, 8'h2A -> depth=3, topValue=8'h2A, highWater=3; then pop twice -> topValue=8'h05, depth=1.
- 16 pushes of values 1..16, then push 8'hFF -> depth=16, full=1, topValue=8'h10, overflowError=1; then push+pop with 8'h77 -> topValue=8'h77, depth=16, no further error.
- Pop on empty -> underflowError=1, depth=0, topValue=0; then clearErrors -> underflowError=0 next cycle.
- Push+pop with 8'h3C on empty -> depth=1, topValue=8'h3C, underflowError=0.
- At depth=5: flush together with push 8'h09 -> depth=0, topValue=0, highWater=0; sticky errors unchanged.
- Assert isResetN=0 between clock edges during a push -> all outputs reset immediately; after release, push 8'h42 -> topValue=8'h42, depth=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and return-stack operation decode
// Sizing constants used by the CPU, ALU and return stack controller.
package cpu_pkg;

  localparam int PC_WIDTH    = 8;
  localparam int STACK_DEPTH = 16;
  localparam int DEPTH_WIDTH = $clog2(STACK_DEPTH) + 1;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_FLUSH,
    OP_TAIL,
    OP_PUSH,
    OP_POP,
    OP_OVERFLOW,
    OP_UNDERFLOW
  } rs_op_e;

  // Single accepted operation per cycle: flush, push+pop, push, pop.
  function automatic rs_op_e decode_op(input logic flush, input logic push,
                                       input logic pop, input logic full,
                                       input logic empty);
    rs_op_e op;
    op = OP_NONE;
    if (flush)              op = OP_FLUSH;
    else if (push && pop)   op = empty ? OP_PUSH : OP_TAIL;
    else if (push)          op = full ? OP_OVERFLOW : OP_PUSH;
    else if (pop)           op = empty ? OP_UNDERFLOW : OP_POP;
    return op;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - return stack storage, one sync write port, one async read port
// Deliberately unreset; the controller never exposes entries above depth.
module stack_ram #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 16,
  localparam int AW         = $clog2(STACK_DEPTH)
) (
  input  logic                clock,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [PC_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [PC_WIDTH-1:0] rd_data
);

  logic [PC_WIDTH-1:0] mem_q [STACK_DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/return_stack_controller.sv
// rtl/return_stack_controller.sv - CALL/EXIT return address stack control
// Depth counter, sticky error flags, high-water mark and registered top entry.
module return_stack_controller
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH    = cpu_pkg::PC_WIDTH,
  parameter int STACK_DEPTH = cpu_pkg::STACK_DEPTH,
  localparam int AW         = $clog2(STACK_DEPTH),
  localparam int DW         = AW + 1
) (
  input  logic                clock,
  input  logic                isResetN,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] pushValue,
  input  logic                flush,
  input  logic                clearErrors,
  output logic [PC_WIDTH-1:0] topValue,
  output logic [DW-1:0]       depth,
  output logic                full,
  output logic                empty,
  output logic                overflowError,
  output logic                underflowError,
  output logic [DW-1:0]       highWater
);

  logic [DW-1:0]       depth_q, depth_d;
  logic [DW-1:0]       high_water_q, high_water_d;
  logic [PC_WIDTH-1:0] top_q, top_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  logic                ram_we;
  logic [AW-1:0]       ram_waddr;
  logic [AW-1:0]       ram_raddr;
  logic [PC_WIDTH-1:0] ram_rdata;
  logic [AW-1:0]       push_idx;
  logic [AW-1:0]       top_idx;
  rs_op_e              op;

  assign full      = (depth_q == DW'(STACK_DEPTH));
  assign empty     = (depth_q == '0);
  assign push_idx  = depth_q[AW-1:0];
  assign top_idx   = depth_q[AW-1:0] - AW'(1);
  // After a pop the new top sits two below the current push index.
  assign ram_raddr = depth_q[AW-1:0] - AW'(2);
  assign op        = decode_op(flush, push, pop, full, empty);

  stack_ram #(
    .PC_WIDTH    (PC_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack_ram (
    .clock   (clock),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (pushValue),
    .rd_addr (ram_raddr),
    .rd_data (ram_rdata)
  );

  always_comb begin
    depth_d      = depth_q;
    top_d        = top_q;
    high_water_d = high_water_q;
    overflow_d   = clearErrors ? 1'b0 : overflow_q;
    underflow_d  = clearErrors ? 1'b0 : underflow_q;
    ram_we       = 1'b0;
    ram_waddr    = push_idx;

    case (op)
      OP_FLUSH: begin
        depth_d = '0;
        top_d   = '0;
      end
      OP_TAIL: begin
        ram_we    = 1'b1;
        ram_waddr = top_idx;
        top_d     = pushValue;
      end
      OP_PUSH: begin
        ram_we  = 1'b1;
        depth_d = depth_q + DW'(1);
        top_d   = pushValue;
      end
      OP_POP: begin
        depth_d = depth_q - DW'(1);
        top_d   = (depth_q == DW'(1)) ? '0 : ram_rdata;
      end
      OP_OVERFLOW:  overflow_d  = 1'b1;
      OP_UNDERFLOW: underflow_d = 1'b1;
      default: ;
    endcase

    if (op == OP_FLUSH)              high_water_d = '0;
    else if (depth_d > high_water_q) high_water_d = depth_d;
  end

  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      depth_q      <= '0;
      top_q        <= '0;
      high_water_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      depth_q      <= depth_d;
      top_q        <= top_d;
      high_water_q <= high_water_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign topValue       = top_q;
  assign depth          = depth_q;
  assign highWater      = high_water_q;
  assign overflowError  = overflow_q;
  assign underflowError = underflow_q;

endmodule
